alu_exec_sequencer: RTL and testbench

//  Multi-cycle controller that sequences one decoded RV64 integer op through reg_file and alu.

---
 rtl/alu_exec_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_sequencer.sv
// rtl/alu_exec_sequencer.sv - sequences one RV64 integer op through reg_file and alu
module alu_exec_sequencer #(
    parameter int ALU_TIMEOUT = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instruction,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    input  logic [63:0]      rf_rs1_val,
    input  logic [63:0]      rf_rs2_val,
    output logic             rf_write_sig,
    output logic [4:0]       rf_write_reg,
    output logic [63:0]      rf_write_val,
    output logic [7:0]       alu_opcode,
    output logic [63:0]      alu_value1,
    output logic [63:0]      alu_value2,
    output logic [1:0]       alu_doALU,
    input  logic [63:0]      alu_result,
    input  logic [1:0]       alu_ready,
    output logic             done,
    output logic             illegal,
    output logic             err,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [7:0] OP_ADD = 8'd0;
    localparam logic [7:0] OP_SUB = 8'd1;
    localparam logic [7:0] OP_MUL = 8'd2;
    localparam logic [7:0] OP_DIV = 8'd3;
    localparam logic [7:0] OP_XOR = 8'd4;
    localparam logic [7:0] OP_AND = 8'd5;
    localparam logic [7:0] OP_OR  = 8'd6;
    localparam logic [7:0] OP_REM = 8'd7;

    // Last WAIT cycle index before the ALU is declared hung
    localparam logic [7:0] TMO_LAST = 8'(ALU_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_OPER, S_WAIT, S_WB, S_ILL
    } state_t;

    state_t      r_state;
    logic        r_is_imm;
    logic [11:0] r_imm;
    logic [7:0]  r_wait_cnt;

    logic        w_legal;
    logic        w_is_imm;
    logic [7:0]  w_opcode;
    logic [9:0]  w_f7f3;
    logic [63:0] w_value2;
    logic        w_div0;

    assign w_f7f3 = {instruction[31:25], instruction[14:12]};

    // Decode the incoming word into an ALU opcode and a legality flag
    always_comb begin
        w_legal  = 1'b0;
        w_is_imm = 1'b0;
        w_opcode = OP_ADD;
        case (instruction[6:0])
            7'b0110011: begin
                w_legal = 1'b1;
                case (w_f7f3)
                    10'b0000000_000: w_opcode = OP_ADD;
                    10'b0100000_000: w_opcode = OP_SUB;
                    10'b0000001_000: w_opcode = OP_MUL;
                    10'b0000001_100: w_opcode = OP_DIV;
                    10'b0000001_110: w_opcode = OP_REM;
                    10'b0000000_100: w_opcode = OP_XOR;
                    10'b0000000_110: w_opcode = OP_OR;
                    10'b0000000_111: w_opcode = OP_AND;
                    default:         w_legal  = 1'b0;
                endcase
            end
            7'b0010011: begin
                w_legal  = 1'b1;
                w_is_imm = 1'b1;
                case (instruction[14:12])
                    3'b000:  w_opcode = OP_ADD;
                    3'b100:  w_opcode = OP_XOR;
                    3'b110:  w_opcode = OP_OR;
                    3'b111:  w_opcode = OP_AND;
                    default: w_legal  = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Operand 2 selection and the divide-by-zero bypass, both only meaningful in OPER,
    // where the registered reg_file data has just arrived
    assign w_value2 = r_is_imm ? {{52{r_imm[11]}}, r_imm} : rf_rs2_val;
    assign w_div0   = ((alu_opcode == OP_DIV) || (alu_opcode == OP_REM)) && (w_value2 == 64'd0);

    assign instr_ready = (r_state == S_IDLE);
    assign alu_value1  = (r_state == S_OPER) ? rf_rs1_val : 64'd0;
    assign alu_value2  = (r_state == S_OPER) ? w_value2 : 64'd0;
    assign alu_doALU   = ((r_state == S_OPER) && !w_div0) ? 2'h1 : 2'h0;

    // Controller FSM with registered pulses, latched addresses and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_is_imm     <= 1'b0;
            r_imm        <= 12'd0;
            r_wait_cnt   <= 8'd0;
            rf_rs1       <= 5'd0;
            rf_rs2       <= 5'd0;
            rf_write_sig <= 1'b0;
            rf_write_reg <= 5'd0;
            rf_write_val <= 64'd0;
            alu_opcode   <= 8'd0;
            done         <= 1'b0;
            illegal      <= 1'b0;
            err          <= 1'b0;
            retire_count <= '0;
        end else begin
            rf_write_sig <= 1'b0;
            done         <= 1'b0;
            illegal      <= 1'b0;
            err          <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        rf_rs1       <= instruction[19:15];
                        rf_rs2       <= instruction[24:20];
                        rf_write_reg <= instruction[11:7];
                        r_imm        <= instruction[31:20];
                        r_is_imm     <= w_is_imm;
                        alu_opcode   <= w_opcode;
                        if (w_legal) begin
                            r_state <= S_READ;
                        end else begin
                            r_state <= S_ILL;
                            illegal <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_wait_cnt <= 8'd0;
                    r_state    <= S_OPER;
                end
                S_OPER: begin
                    if (w_div0) begin
                        rf_write_val <= (alu_opcode == OP_DIV) ? {64{1'b1}} : rf_rs1_val;
                        rf_write_sig <= 1'b1;
                        done         <= 1'b1;
                        retire_count <= retire_count + 1'b1;
                        r_state      <= S_WB;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (alu_ready == 2'h1) begin
                        rf_write_val <= alu_result;
                        rf_write_sig <= 1'b1;
                        done         <= 1'b1;
                        retire_count <= retire_count + 1'b1;
                        r_state      <= S_WB;
                    end else if (r_wait_cnt == TMO_LAST) begin
                        err     <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_WB:    r_state <= S_IDLE;
                S_ILL:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb/tb_alu_exec_sequencer.sv - scoreboard bench for alu_exec_sequencer
module tb_alu_exec_sequencer;

    typedef struct {
        logic [31:0] instr;
        int          kind;
        logic [4:0]  rd;
        logic [63:0] val;
        int          lat;
        int          alu_cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instruction = 32'd0;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [63:0] rf_rs1_val, rf_rs2_val;
    logic        rf_write_sig;
    logic [4:0]  rf_write_reg;
    logic [63:0] rf_write_val;
    logic [7:0]  alu_opcode;
    logic [63:0] alu_value1, alu_value2;
    logic [1:0]  alu_doALU;
    logic [63:0] alu_result;
    logic [1:0]  alu_ready;
    logic        done, illegal, err;
    logic [3:0]  retire_count;

    logic        alu_stall = 1'b0;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        sb[$];
    vec_t        tbl[18];
    logic [63:0] rf_mem[32];

    alu_exec_sequencer #(.ALU_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
        .rf_write_sig(rf_write_sig), .rf_write_reg(rf_write_reg), .rf_write_val(rf_write_val),
        .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2),
        .alu_doALU(alu_doALU), .alu_result(alu_result), .alu_ready(alu_ready),
        .done(done), .illegal(illegal), .err(err), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: registered read, x0 hard-wired to zero, preloaded during reset
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 64'd0;
            rf_mem[1]  <= 64'd5;
            rf_mem[2]  <= 64'd7;
            rf_mem[8]  <= 64'd9;
            rf_mem[11] <= 64'hF0F0;
            rf_mem[12] <= 64'h0FF0;
            rf_rs1_val <= 64'd0;
            rf_rs2_val <= 64'd0;
        end else begin
            rf_rs1_val <= rf_mem[rf_rs1];
            rf_rs2_val <= rf_mem[rf_rs2];
            if (rf_write_sig && rf_write_reg != 5'd0) rf_mem[rf_write_reg] <= rf_write_val;
        end
    end

    function automatic logic [63:0] alu_fn(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            8'd0: return a + b;
            8'd1: return a - b;
            8'd2: return a * b;
            8'd3: return (b == 64'd0) ? {64{1'b1}} : 64'($signed(a) / $signed(b));
            8'd4: return a ^ b;
            8'd5: return a & b;
            8'd6: return a | b;
            8'd7: return (b == 64'd0) ? a : 64'($signed(a) % $signed(b));
            default: return 64'd0;
        endcase
    endfunction

    // ALU model: registered result one cycle after doALU, ready suppressed when stalled
    always @(posedge clk) begin
        if (reset) begin
            alu_result <= 64'd0;
            alu_ready  <= 2'h0;
        end else if (alu_doALU == 2'h1) begin
            alu_result <= alu_fn(alu_opcode, alu_value1, alu_value2);
            alu_ready  <= alu_stall ? 2'h0 : 2'h1;
        end else begin
            alu_ready <= 2'h0;
        end
    end

    function automatic logic [31:0] rt(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] it(input logic [11:0] imm, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor: pops one expectation per done/illegal/err pulse
    task automatic monitor();
        int       accept_cyc = 0;
        int       alu_cyc = 0;
        int       kind_act;
        logic [3:0] exp_cnt = 4'd0;
        vec_t     e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_cnt = 4'd0;
                alu_cyc = 0;
            end else begin
                if (instr_valid && instr_ready) accept_cyc = cyc + 1;
                if (alu_doALU == 2'h1) alu_cyc++;
                if (rf_write_sig !== done) check("write_sig_vs_done", 64'(rf_write_sig), 64'(done));
                if (done || illegal || err) begin
                    kind_act = done ? 0 : (illegal ? 1 : 2);
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", 64'(kind_act + 1), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("kind", 64'(kind_act), 64'(e.kind));
                        check("latency", 64'(cyc - accept_cyc), 64'(e.lat));
                        check("alu_cycles", 64'(alu_cyc), 64'(e.alu_cyc));
                        if (e.kind == 0) begin
                            exp_cnt = exp_cnt + 4'd1;
                            check("wr_reg", 64'(rf_write_reg), 64'(e.rd));
                            check("wr_val", rf_write_val, e.val);
                        end
                        if (e.kind == 2) check("err_ready", 64'(instr_ready), 64'd1);
                        check("retire_count", 64'(retire_count), 64'(exp_cnt));
                    end
                    alu_cyc = 0;
                end
            end
        end
    endtask

    task automatic issue(input logic [31:0] ins);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_issue", 64'(instr_ready), 64'd1);
        instr_valid = 1'b1;
        instruction = ins;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        sb.push_back(v);
        issue(v.instr);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        fork monitor(); join_none

        tbl[0]  = '{rt(7'h00, 3'b000, 5'd3, 5'd1, 5'd2),  0, 5'd3,  64'd12, 3, 1};
        tbl[1]  = '{rt(7'h20, 3'b000, 5'd4, 5'd1, 5'd2),  0, 5'd4,  64'hFFFF_FFFF_FFFF_FFFE, 3, 1};
        tbl[2]  = '{it(12'hFFF, 3'b000, 5'd5, 5'd0),      0, 5'd5,  {64{1'b1}}, 3, 1};
        tbl[3]  = '{rt(7'h01, 3'b100, 5'd6, 5'd8, 5'd0),  0, 5'd6,  {64{1'b1}}, 2, 0};
        tbl[4]  = '{rt(7'h01, 3'b110, 5'd7, 5'd8, 5'd0),  0, 5'd7,  64'd9, 2, 0};
        tbl[5]  = '{rt(7'h01, 3'b000, 5'd13, 5'd1, 5'd2), 0, 5'd13, 64'd35, 3, 1};
        tbl[6]  = '{rt(7'h01, 3'b100, 5'd14, 5'd8, 5'd1), 0, 5'd14, 64'd1, 3, 1};
        tbl[7]  = '{rt(7'h01, 3'b110, 5'd15, 5'd8, 5'd1), 0, 5'd15, 64'd4, 3, 1};
        tbl[8]  = '{rt(7'h00, 3'b100, 5'd16, 5'd11, 5'd12), 0, 5'd16, 64'hFF00, 3, 1};
        tbl[9]  = '{rt(7'h00, 3'b111, 5'd17, 5'd11, 5'd12), 0, 5'd17, 64'h00F0, 3, 1};
        tbl[10] = '{rt(7'h00, 3'b110, 5'd18, 5'd11, 5'd12), 0, 5'd18, 64'hFFF0, 3, 1};
        tbl[11] = '{it(12'h0FF, 3'b100, 5'd19, 5'd11),    0, 5'd19, 64'hF00F, 3, 1};
        tbl[12] = '{it(12'hFF0, 3'b111, 5'd20, 5'd11),    0, 5'd20, 64'hF0F0, 3, 1};
        tbl[13] = '{it(12'h7FF, 3'b110, 5'd21, 5'd1),     0, 5'd21, 64'h7FF, 3, 1};
        tbl[14] = '{rt(7'h00, 3'b000, 5'd0, 5'd1, 5'd2),  0, 5'd0,  64'd12, 3, 1};
        tbl[15] = '{32'h0020_8063,                         1, 5'd0,  64'd0, 0, 0};
        tbl[16] = '{rt(7'h20, 3'b100, 5'd9, 5'd1, 5'd2),  1, 5'd0,  64'd0, 0, 0};
        tbl[17] = '{it(12'h001, 3'b001, 5'd9, 5'd1),      1, 5'd0,  64'd0, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_instr_ready", 64'(instr_ready), 64'd1);
        check("rst_write_sig", 64'(rf_write_sig), 64'd0);
        check("rst_doalu", 64'(alu_doALU), 64'd0);
        check("rst_pulses", 64'({done, illegal, err}), 64'd0);
        check("rst_rs1", 64'(rf_rs1), 64'd0);
        check("rst_write_val", rf_write_val, 64'd0);
        check("rst_opcode", 64'(alu_opcode), 64'd0);
        check("rst_count", 64'(retire_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) run_vec(tbl[i]);
        check("count_after_table", 64'(retire_count), 64'd15);

        // Counter wraps from 15 to 0
        run_vec('{rt(7'h00, 3'b000, 5'd24, 5'd1, 5'd2), 0, 5'd24, 64'd12, 3, 1});
        check("count_wrap", 64'(retire_count), 64'd0);

        // Back-to-back with valid held high: accepts exactly 5 cycles apart
        sb.push_back('{rt(7'h00, 3'b000, 5'd25, 5'd1, 5'd2), 0, 5'd25, 64'd12, 3, 1});
        sb.push_back('{rt(7'h20, 3'b000, 5'd26, 5'd2, 5'd1), 0, 5'd26, 64'd2, 3, 1});
        instr_valid = 1'b1;
        instruction = rt(7'h00, 3'b000, 5'd25, 5'd1, 5'd2);
        @(posedge clk); #1;
        instruction = rt(7'h20, 3'b000, 5'd26, 5'd2, 5'd1);
        k = 0;
        while (!instr_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("b2b_spacing", 64'(k + 1), 64'd5);
        wait_drain();

        // ALU never ready: err after the WAIT timeout, no write, count unchanged
        alu_stall = 1'b1;
        run_vec('{rt(7'h00, 3'b000, 5'd22, 5'd1, 5'd2), 2, 5'd0, 64'd0, 6, 1});
        alu_stall = 1'b0;
        check("count_after_err", 64'(retire_count), 64'd2);
        check("x22_unwritten", rf_mem[22], 64'd0);

        // Reset while in OPER: immediate abort
        issue(rt(7'h00, 3'b000, 5'd23, 5'd1, 5'd2));
        @(posedge clk); #1;
        check("oper_doalu", 64'(alu_doALU), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_ready", 64'(instr_ready), 64'd1);
        check("midrst_doalu", 64'(alu_doALU), 64'd0);
        check("midrst_write_sig", 64'(rf_write_sig), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_value1", alu_value1, 64'd0);
        check("midrst_count", 64'(retire_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_queue", 64'(sb.size()), 64'd0);
        check("post_rst_count", 64'(retire_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
